// File: rtl/bobing_round_ctrl.sv
// rtl/bobing_round_ctrl.sv - BoBing turn sequencer: roll capture, prize award, round-robin turns.
// Optional finite mooncake pool enabled by defining BOBING_POOL_EN.
module bobing_round_ctrl #(
  parameter int NUM_PLAYERS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        roll_valid,
  output logic        roll_ready,
  input  logic [17:0] roll_dice,
  output logic [17:0] score_dice,
  input  logic [5:0]  score_prize,
  output logic        award_valid,
  output logic [2:0]  award_player,
  output logic [2:0]  award_tier,
  output logic        award_granted,
  output logic        roll_invalid,
  output logic [2:0]  cur_player,
  output logic [6:0]  pool_left,
  output logic        game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ROLL = 3'd1,
    SCORE     = 3'd2,
    AWARD     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [17:0] dice_q;
  logic [5:0]  prize_q;
  logic [2:0]  player_q;
  logic        inv_q;
  logic        bad_die;
  logic        start_ok;
  logic        roll_fire;
  logic [2:0]  win_tier;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_idx;
  logic        tier_avail;
  logic        last_cake;

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign roll_fire = roll_valid && (state == WAIT_ROLL);

  always_comb begin
    bad_die = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (roll_dice[3*i +: 3] == 3'd0 || roll_dice[3*i +: 3] == 3'd7) bad_die = 1'b1;
    end
  end

  // More than one flag from the scorer is a fault and pays nothing.
  always_comb begin
    bit_cnt = 3'd0;
    bit_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (prize_q[i]) begin
        bit_cnt = bit_cnt + 3'd1;
        bit_idx = 3'(i + 1);
      end
    end
    win_tier = (bit_cnt == 3'd1) ? bit_idx : 3'd0;
  end

`ifdef BOBING_POOL_EN
  logic [5:0] pool_q [6];
  logic [6:0] left_q;

  always_comb begin
    tier_avail = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (win_tier == 3'(i + 1) && pool_q[i] != 6'd0) tier_avail = 1'b1;
    end
  end

  assign last_cake = tier_avail && (left_q == 7'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) pool_q[i] <= 6'd0;
      left_q <= 7'd0;
    end else if (start_ok) begin
      for (int i = 0; i < 6; i++) pool_q[i] <= 6'(1 << i);
      left_q <= 7'd63;
    end else if (state == AWARD && tier_avail) begin
      for (int i = 0; i < 6; i++) begin
        if (win_tier == 3'(i + 1)) pool_q[i] <= pool_q[i] - 6'd1;
      end
      left_q <= left_q - 7'd1;
    end
  end

  assign pool_left = left_q;
  assign game_over = (state == DONE);
`else
  assign tier_avail = (win_tier != 3'd0);
  assign last_cake  = 1'b0;
  assign pool_left  = 7'd0;
  assign game_over  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = WAIT_ROLL;
      WAIT_ROLL: if (roll_valid && !bad_die) state_nxt = SCORE;
      SCORE:     state_nxt = AWARD;
      AWARD:     state_nxt = last_cake ? DONE : WAIT_ROLL;
      DONE:      if (start) state_nxt = WAIT_ROLL;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dice_q   <= 18'd0;
      prize_q  <= 6'd0;
      player_q <= 3'd0;
      inv_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      inv_q <= roll_fire && bad_die;
      // Rejected rolls never reach the scorer, so the dice register keeps the last good roll.
      if (roll_fire && !bad_die) dice_q <= roll_dice;
      if (state == SCORE) prize_q <= score_prize;
      if (start_ok) begin
        player_q <= 3'd0;
      end else if (state == AWARD) begin
        player_q <= (player_q == 3'(NUM_PLAYERS - 1)) ? 3'd0 : player_q + 3'd1;
      end
    end
  end

  assign roll_ready    = (state == WAIT_ROLL);
  assign score_dice    = dice_q;
  assign award_valid   = (state == AWARD);
  assign award_player  = award_valid ? player_q : 3'd0;
  assign award_tier    = award_valid ? win_tier : 3'd0;
  assign award_granted = award_valid && tier_avail;
  assign roll_invalid  = inv_q;
  assign cur_player    = player_q;

endmodule

// File: tb/tb_bobing_round_ctrl.sv
// tb/tb_bobing_round_ctrl.sv - directed bench for bobing_round_ctrl with NUM_PLAYERS=3.
// Expectations follow BOBING_POOL_EN when the bench is built with it.
module tb_bobing_round_ctrl;

`ifdef BOBING_POOL_EN
  localparam bit POOL_EN = 1'b1;
`else
  localparam bit POOL_EN = 1'b0;
`endif
  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        roll_valid = 1'b0;
  logic        roll_ready;
  logic [17:0] roll_dice = 18'd0;
  logic [17:0] score_dice;
  logic [5:0]  score_prize = 6'd0;
  logic        award_valid;
  logic [2:0]  award_player;
  logic [2:0]  award_tier;
  logic        award_granted;
  logic        roll_invalid;
  logic [2:0]  cur_player;
  logic [6:0]  pool_left;
  logic        game_over;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_player = 0;
  int exp_pool   = 0;

  bobing_round_ctrl #(.NUM_PLAYERS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .roll_valid(roll_valid), .roll_ready(roll_ready), .roll_dice(roll_dice),
    .score_dice(score_dice), .score_prize(score_prize),
    .award_valid(award_valid), .award_player(award_player), .award_tier(award_tier),
    .award_granted(award_granted), .roll_invalid(roll_invalid),
    .cur_player(cur_player), .pool_left(pool_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [17:0] pack(input int d1, d2, d3, d4, d5, d6);
    return {3'(d6), 3'(d5), 3'(d4), 3'(d3), 3'(d2), 3'(d1)};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_player = 0;
    exp_pool   = POOL_EN ? 63 : 0;
  endtask

  task automatic do_roll(input logic [17:0] dice, input logic [5:0] prize,
                         input int tier, input bit granted, input bit quiet);
    check("ready_before_roll", roll_ready, 1);
    roll_dice   = dice;
    score_prize = prize;
    roll_valid  = 1'b1;
    @(negedge clk);
    roll_valid = 1'b0;
    if (!quiet) begin
      check("score_dice", score_dice, dice);
      check("no_award_in_score", award_valid, 0);
    end
    @(negedge clk);
    check("award_valid", award_valid, 1);
    check("award_player", award_player, exp_player);
    check("award_tier", award_tier, tier);
    check("award_granted", award_granted, granted);
    if (granted && POOL_EN) exp_pool--;
    exp_player = (exp_player == NP - 1) ? 0 : exp_player + 1;
    @(negedge clk);
    if (!quiet) check("award_pulse_end", award_valid, 0);
    check("cur_player", cur_player, exp_player);
    check("pool_left", pool_left, exp_pool);
    check("game_over", game_over, POOL_EN && exp_pool == 0);
    check("ready_after", roll_ready, !(POOL_EN && exp_pool == 0));
  endtask

  task automatic do_invalid(input logic [17:0] dice);
    roll_dice  = dice;
    roll_valid = 1'b1;
    @(negedge clk);
    roll_valid = 1'b0;
    check("invalid_pulse", roll_invalid, 1);
    check("invalid_ready", roll_ready, 1);
    check("invalid_no_award", award_valid, 0);
    @(negedge clk);
    check("invalid_pulse_end", roll_invalid, 0);
    check("invalid_no_award2", award_valid, 0);
    check("invalid_player", cur_player, exp_player);
    check("invalid_pool", pool_left, exp_pool);
  endtask

  initial begin
    @(negedge clk);
    check("rst_ready", roll_ready, 0);
    check("rst_award_valid", award_valid, 0);
    check("rst_player", cur_player, 0);
    check("rst_pool", pool_left, 0);
    check("rst_score_dice", score_dice, 0);
    check("rst_game_over", game_over, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", roll_ready, 0);

    pulse_start();
    check("start_ready", roll_ready, 1);
    check("start_pool", pool_left, exp_pool);
    check("start_player", cur_player, 0);

    do_roll(pack(4, 4, 4, 4, 1, 6), 6'b000001, 1, 1'b1, 1'b0);

    // start mid-game must not reset the turn or pool
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_player", cur_player, 1);
    check("start_ignored_pool", pool_left, exp_pool);

    do_roll(pack(4, 4, 4, 4, 2, 3), 6'b000001, 1, !POOL_EN, 1'b0);
    do_invalid(pack(3, 7, 2, 5, 1, 6));
    do_invalid(pack(1, 2, 3, 4, 5, 0));
    do_roll(pack(1, 1, 2, 2, 3, 3), 6'b000011, 0, 1'b0, 1'b0);
    check("wrap_player", cur_player, 0);
    do_roll(pack(2, 3, 5, 6, 6, 1), 6'b000000, 0, 1'b0, 1'b0);
    do_roll(pack(4, 2, 3, 5, 1, 6), 6'b100000, 6, 1'b1, 1'b0);

    // reset in the middle of SCORE
    roll_dice   = pack(4, 4, 1, 2, 3, 5);
    score_prize = 6'b000100;
    roll_valid  = 1'b1;
    @(negedge clk);
    roll_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", roll_ready, 0);
    check("mid_rst_award", award_valid, 0);
    check("mid_rst_tier", award_tier, 0);
    check("mid_rst_granted", award_granted, 0);
    check("mid_rst_player", cur_player, 0);
    check("mid_rst_pool", pool_left, 0);
    check("mid_rst_dice", score_dice, 0);
    check("mid_rst_invalid", roll_invalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_award", award_valid, 0);
    end

    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      for (int r = 0; r < (POOL_EN ? (1 << (k - 1)) : 1); r++) begin
        do_roll(pack(k, 2, 3, 4, 5, 6), 6'(1 << (k - 1)), k, 1'b1, 1'b1);
      end
    end

`ifdef BOBING_POOL_EN
    check("drained_game_over", game_over, 1);
    check("drained_ready", roll_ready, 0);
    pulse_start();
    check("restart_pool", pool_left, 63);
    check("restart_player", cur_player, 0);
    check("restart_game_over", game_over, 0);
    check("restart_ready", roll_ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bobing_round_ctrl.md
# bobing_round_ctrl

Sequencing controller for the BoBing scoring datapath. Accepts one six-dice roll per turn, checks the face codes, and presents the dice to the combinational scorer (P1..P6 prize flags). It awards the resulting prize tier against a finite mooncake pool and rotates turns round-robin among `NUM_PLAYERS` players. The game ends when the pool is exhausted. It sits between the roll source (dice generator or host) and the scorer.

## Interface
- `NUM_PLAYERS`, default 6: number of players, legal range 2..8.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse; starts or restarts a game; honoured only in IDLE or DONE.
- `roll_valid`  in  1: a roll is offered on `roll_dice`.
- `roll_ready`  out  1: controller accepts a roll this cycle.
- `roll_dice`  in  18: die1 = [2:0] … die6 = [17:15]; each die is face code 1..6.
- `score_dice`  out  18: registered dice driven to the scorer, same packing.
- `score_prize`  in  6: scorer flags, bit0 = P1 (top tier) … bit5 = P6 (lowest tier).
- `award_valid`  out  1: one-cycle pulse; the award fields are valid.
- `award_player`  out  3: player index 0..NUM_PLAYERS-1 for the turn.
- `award_tier`  out  3: tier 1..6; 0 = no prize.
- `award_granted`  out  1: the tier was paid from the pool.
- `roll_invalid`  out  1: one-cycle pulse; the accepted roll had a die code of 0 or 7.
- `cur_player`  out  3: player whose turn is pending.
- `pool_left`  out  7: total cakes remaining, 0..63.
- `game_over`  out  1: high in DONE.

## Operation
- FSM states: IDLE, WAIT_ROLL, SCORE, AWARD, DONE.
- IDLE: all outputs are 0. `start` loads the pools, sets `cur_player`=0, and moves to WAIT_ROLL.
- Pools, tier k = 1..6: initial count 2^(k-1), giving 1, 2, 4, 8, 16 and 32, for a total of 63. Each tier counter is 6 bits wide.
- WAIT_ROLL: `roll_ready`=1. When `roll_valid`&&`roll_ready`, the controller captures `roll_dice` into the dice register.
  - If any die is 0 or 7: pulse `roll_invalid` on the next cycle and stay in WAIT_ROLL. The turn is not consumed and `cur_player` is unchanged. The scorer is not used.
  - Otherwise: go to SCORE.
- SCORE: lasts one cycle. `score_dice` holds the captured roll. At the end of the cycle, `score_prize` is sampled into the prize register.
- AWARD: lasts one cycle. `award_valid`=1 and `award_player`=`cur_player`.
  - Zero prize bits set: `award_tier`=0, `award_granted`=0.
  - Exactly one bit set: `award_tier` = bit index + 1. If that tier's pool is nonzero, set `award_granted`=1, decrement that tier's counter, and decrement `pool_left`. If the pool is 0, `award_granted`=0 and the tier is not downgraded.
  - Two or more bits set: treated as a scorer fault. `award_tier`=0 and `award_granted`=0.
- After AWARD, `cur_player` advances by 1 and wraps from NUM_PLAYERS-1 to 0. If `pool_left` reaches 0, the FSM enters DONE; otherwise it returns to WAIT_ROLL.
- DONE: `game_over`=1 and `roll_ready`=0. `start` restarts the game exactly as from IDLE.
- `start` in WAIT_ROLL, SCORE or AWARD is ignored.
- `score_dice` holds its value outside SCORE.

## Timing
- Reset values: state IDLE; `roll_ready`, `award_valid`, `award_granted`, `roll_invalid` and `game_over` are 0; `award_tier`, `award_player`, `cur_player`, `score_dice` and `pool_left` are 0.
- Roll accepted at edge N → SCORE during cycle N+1 → `award_valid` high during cycle N+2 → `roll_ready` high again in cycle N+3. Peak throughput is one roll per 3 cycles.
- Invalid roll accepted at edge N: `roll_invalid` is high in cycle N+1 and `roll_ready` stays high, so the next roll can be accepted at edge N+1.
- The scorer must settle within one clock; no multicycle path is allowed.
- Asserting `rst_n` low mid-turn immediately forces IDLE. No award is emitted and the pools are cleared.
- `pool_left` updates on the same edge at which `award_valid` falls.

## Configuration
- `BOBING_POOL_EN` defined: finite pool as described; `game_over` and DONE are reachable.
- `BOBING_POOL_EN` undefined: no pool counters. Every single-tier prize sets `award_granted`=1. `pool_left` is tied to 0 and `game_over` is tied to 0. The game runs until reset; DONE is unreachable.

## Test plan
- Reset, `start`, roll {4,4,4,4,1,6} with the scorer returning `score_prize`=6'b000001 → `award_valid` at edge N+2, player 0, tier 1, granted=1; `pool_left` 63→62; `cur_player`=1.
- Second tier-1 prize, for player 1 → tier 1, granted=0; `pool_left` stays 62; `cur_player`=2.
- Roll containing die code 7 → `roll_invalid` pulse; no `award_valid`; `cur_player` unchanged; `pool_left` unchanged.
- `score_prize`=6'b000011 → `award_tier`=0, granted=0; turn advances.
- NUM_PLAYERS=3: after 3 awards `cur_player` wraps to 0. Draining all 63 cakes → `game_over`=1 and `roll_ready`=0; `start` → pools back to 63 and `cur_player`=0.
- `rst_n` pulsed low during SCORE → all outputs are 0 within the same cycle; no `award_valid` follows.
